// File: rtl/hebb_recall_unit_pkg.sv
// Shared sizing, state encoding and sign helper for the Hebbian recall path.
// The weight learner uses the same N/WW/SW so the packed buses line up.
package hebb_recall_unit_pkg;

    localparam int N     = 20;
    localparam int WW    = 10;
    localparam int SW    = 2;
    localparam int ACC_W = 17;
    localparam int PW    = WW + SW;
    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic signed [SW-1:0] POS_ONE = 2'sd1;
    localparam logic signed [SW-1:0] NEG_ONE = -2'sd1;

    // Bipolar threshold: zero keeps the previous state.
    function automatic logic signed [SW-1:0] sign_state(
        input logic signed [ACC_W-1:0] a,
        input logic signed [SW-1:0]    prev
    );
        if (a[ACC_W-1])
            return NEG_ONE;
        else if (a != '0)
            return POS_ONE;
        return prev;
    endfunction

endpackage

// File: rtl/hebb_recall_unit_if.sv
// Request/response bundle between the recall controller and the unit.
// master = controller side, slave = recall unit side.
interface hebb_recall_unit_if
    import hebb_recall_unit_pkg::*;
();

    logic                    start;
    logic [N*WW-1:0]         weights_packed;
    logic [N*SW-1:0]         xalt;
    logic                    busy;
    logic                    done;
    logic signed [ACC_W-1:0] sum;
    logic signed [SW-1:0]    xout;

    modport master (
        output start,
        output weights_packed,
        output xalt,
        input  busy,
        input  done,
        input  sum,
        input  xout
    );

    modport slave (
        input  start,
        input  weights_packed,
        input  xalt,
        output busy,
        output done,
        output sum,
        output xout
    );

endinterface

// File: rtl/hebb_recall_unit_mac_slice.sv
// One signed weight x neuron product added onto the running sum.
// Shared across all N iterations; the caller muxes the operands by index.
module hebb_mac_slice
    import hebb_recall_unit_pkg::*;
(
    input  logic signed [WW-1:0]    w,
    input  logic signed [SW-1:0]    x,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [ACC_W-1:0] acc_out
);

    logic signed [PW-1:0] w_ext;
    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] prod;

    // Extend both operands to the full product width so -2 stays -2.
    assign w_ext = {{SW{w[WW-1]}}, w};
    assign x_ext = {{WW{x[SW-1]}}, x};
    assign prod  = w_ext * x_ext;

    assign acc_out = acc_in + {{(ACC_W-PW){prod[PW-1]}}, prod};

endmodule

// File: rtl/hebb_recall_unit.sv
// Serial Hebbian recall: snapshots weights/states, does one MAC per
// clock for N terms, then thresholds the sum into a new bipolar state.
module hebb_recall_unit
    import hebb_recall_unit_pkg::*;
(
    input  logic               recall_clock,
    input  logic               rst,
    hebb_recall_unit_if.slave  bus
);

    state_t                  state;
    state_t                  state_n;
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nx;
    logic signed [ACC_W-1:0] sum_r;
    logic signed [SW-1:0]    xout_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    last;
    logic signed [WW-1:0]    w_snap [N];
    logic signed [SW-1:0]    x_snap [N];

    assign last = (idx == IDX_W'(N - 1));

    hebb_mac_slice u_mac (
        .w       (w_snap[idx]),
        .x       (x_snap[idx]),
        .acc_in  (acc),
        .acc_out (acc_nx)
    );

    // Next-state decode: IDLE waits for start, ACC runs N terms, FIN is one cycle.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.start) state_n = ACC;
            ACC:  if (last)      state_n = FIN;
            FIN:                 state_n = IDLE;
            default:             state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge recall_clock or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Datapath: snapshot on accept, accumulate, then publish result and pulse done.
    always_ff @(posedge recall_clock or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            acc    <= '0;
            sum_r  <= '0;
            xout_r <= POS_ONE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            for (int j = 0; j < N; j++) begin
                w_snap[j] <= '0;
                x_snap[j] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int j = 0; j < N; j++) begin
                            w_snap[j] <= bus.weights_packed[j*WW +: WW];
                            x_snap[j] <= bus.xalt[j*SW +: SW];
                        end
                        acc    <= '0;
                        idx    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                ACC: begin
                    acc <= acc_nx;
                    idx <= idx + 1'b1;
                    if (last)
                        busy_r <= 1'b0;
                end
                FIN: begin
                    sum_r  <= acc;
                    xout_r <= sign_state(acc, xout_r);
                    done_r <= 1'b1;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.xout = xout_r;

endmodule

// File: tb/tb_hebb_recall_unit.sv
// Directed bench for hebb_recall_unit: table of recalls run back-to-back,
// plus snapshot, mid-run reset and restart sequences.
module tb_hebb_recall_unit;
    import hebb_recall_unit_pkg::*;

    typedef struct {
        logic [N*WW-1:0] w;
        logic [N*SW-1:0] x;
        int              sum;
        int              xout;
    } vec_t;

    localparam int NV = 8;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    hebb_recall_unit_if bus();

    hebb_recall_unit dut (
        .recall_clock (clk),
        .rst          (rst),
        .bus          (bus)
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [N*WW-1:0] w_all(input int v);
        logic [N*WW-1:0] r;
        for (int j = 0; j < N; j++)
            r[j*WW +: WW] = v[WW-1:0];
        return r;
    endfunction

    function automatic logic [N*SW-1:0] x_all(input int v);
        logic [N*SW-1:0] r;
        for (int j = 0; j < N; j++)
            r[j*SW +: SW] = v[SW-1:0];
        return r;
    endfunction

    // Starts a recall from a negedge; optionally rewrites weights and
    // re-asserts start at cycle dist_k. Returns at the negedge of done.
    task automatic run_recall(
        input  logic [N*WW-1:0] wp,
        input  logic [N*SW-1:0] xp,
        input  int              dist_k,
        output int              done_k,
        output int              busy_n,
        output int              busy_at_done,
        output int              sum_v,
        output int              xout_v
    );
        bus.weights_packed = wp;
        bus.xalt           = xp;
        bus.start          = 1'b1;
        done_k       = -1;
        busy_n       = 0;
        busy_at_done = -1;
        sum_v        = -99999;
        xout_v       = -99;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0)
                bus.start = 1'b0;
            if (k == dist_k) begin
                bus.weights_packed = w_all(100);
                bus.start          = 1'b1;
            end
            if (k == dist_k + 1)
                bus.start = 1'b0;
            if (bus.busy)
                busy_n++;
            if (bus.done) begin
                done_k       = k;
                busy_at_done = int'(bus.busy);
                sum_v        = int'(bus.sum);
                xout_v       = int'(bus.xout);
                break;
            end
            @(posedge clk);
        end
        if (done_k < 0)
            @(negedge clk);
    endtask

    task automatic check_run(
        input string nm,
        input int    done_k,
        input int    busy_n,
        input int    busy_at_done,
        input int    sum_v,
        input int    xout_v,
        input int    exp_sum,
        input int    exp_xout
    );
        check({nm, "_done_cycle"}, done_k, N + 1);
        check({nm, "_busy_cycles"}, busy_n, N);
        check({nm, "_busy_at_done"}, busy_at_done, 0);
        check({nm, "_sum"}, sum_v, exp_sum);
        check({nm, "_xout"}, xout_v, exp_xout);
    endtask

    initial begin
        vec_t            tbl [NV];
        logic [N*WW-1:0] wv;
        logic [N*SW-1:0] xv;
        int              dk, bn, bd, sv, xo;
        int              cnt_done, cnt_busy;

        tbl[0] = '{w: w_all(7),  x: x_all(1), sum: 140,  xout: 1};
        tbl[1] = '{w: w_all(-3), x: x_all(1), sum: -60,  xout: -1};
        wv = w_all(0);
        wv[19*WW +: WW] = 10'sd511;
        xv = x_all(1);
        xv[19*SW +: SW] = 2'b10;
        tbl[2] = '{w: wv, x: xv, sum: -1022, xout: -1};
        tbl[3] = '{w: w_all(0), x: x_all(1), sum: 0, xout: -1};
        for (int j = 0; j < N; j++) begin
            int t;
            t = j - 10;
            wv[j*WW +: WW] = t[WW-1:0];
            xv[j*SW +: SW] = (j % 2 == 0) ? 2'b01 : 2'b11;
        end
        tbl[4] = '{w: wv, x: xv, sum: -10, xout: -1};
        tbl[5] = '{w: w_all(-512), x: x_all(-2), sum: 20480, xout: 1};
        tbl[6] = '{w: w_all(5), x: x_all(0), sum: 0, xout: 1};
        for (int j = 0; j < N; j++) begin
            int t;
            t = j + 1;
            wv[j*WW +: WW] = t[WW-1:0];
        end
        xv = x_all(1);
        xv[0 +: SW] = 2'b10;
        tbl[7] = '{w: wv, x: xv, sum: 207, xout: 1};

        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.weights_packed = '0;
        bus.xalt           = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_sum", int'(bus.sum), 0);
        check("reset_xout", int'(bus.xout), 1);
        rst = 1'b0;
        @(negedge clk);

        // Consecutive calls assert start in the done cycle (back-to-back).
        for (int i = 0; i < NV; i++) begin
            run_recall(tbl[i].w, tbl[i].x, -1, dk, bn, bd, sv, xo);
            check_run($sformatf("vec%0d", i), dk, bn, bd, sv, xo,
                      tbl[i].sum, tbl[i].xout);
        end

        // Weights change and start re-asserted mid-run: snapshot must hold.
        run_recall(w_all(2), x_all(1), 5, dk, bn, bd, sv, xo);
        check_run("snapshot", dk, bn, bd, sv, xo, 40, 1);
        cnt_done = 0;
        cnt_busy = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done) cnt_done++;
            if (bus.busy) cnt_busy++;
        end
        check("snapshot_extra_done", cnt_done, 0);
        check("snapshot_extra_busy", cnt_busy, 0);

        // Leave a non-reset result so the abort is observable.
        run_recall(w_all(-3), x_all(1), -1, dk, bn, bd, sv, xo);
        check_run("pre_abort", dk, bn, bd, sv, xo, -60, -1);

        bus.weights_packed = w_all(7);
        bus.xalt           = x_all(1);
        bus.start          = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 0)
                bus.start = 1'b0;
            if (k == 10)
                break;
            @(posedge clk);
        end
        check("abort_busy_before", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_sum", int'(bus.sum), 0);
        check("abort_xout", int'(bus.xout), 1);
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0;
        cnt_busy = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done) cnt_done++;
            if (bus.busy) cnt_busy++;
        end
        check("abort_no_done", cnt_done, 0);
        check("abort_no_busy", cnt_busy, 0);

        run_recall(w_all(-3), x_all(1), -1, dk, bn, bd, sv, xo);
        check_run("restart", dk, bn, bd, sv, xo, -60, -1);
        @(negedge clk);
        check("restart_done_pulse", int'(bus.done), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
